icache_fetcher: RTL
===================

Name: icache_fetcher

Overview:
- Instruction-fetch stage directly upstream of the memory controller's fetcher port.
- Holds the PC and a direct-mapped, one-word-per-line instruction cache.
- On a hit, delivers one instruction per cycle to the instruction queue.
- On a miss, issues a word read through the memory controller's req/done handshake, fills the line, then resumes. PC redirects from the ROB (mispredict/flush) are honoured at any time.

Parameters:
- ICACHE_LINES, 64, number of cache lines, each one 32-bit word; power of two.
- INDEX_W, 6, log2(ICACHE_LINES).
- RESET_PC, 32'h0, PC value loaded at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- mem_req_o  out  1  fetch request to memory controller; held high until mem_done_i.
- mem_addr_o  out  32  word-aligned fetch address; stable while mem_req_o is high.
- mem_done_i  in  1  one-cycle pulse; mem_data_i is valid in the same cycle.
- mem_data_i  in  32  fetched little-endian word.
- iq_full_i  in  1  instruction queue cannot accept an entry this cycle.
- inst_valid_o  out  1  one-cycle pulse; instruction handed to queue.
- inst_o  out  32  instruction word.
- inst_pc_o  out  32  PC of inst_o.
- redirect_i  in  1  ROB flush/mispredict.
- redirect_pc_i  in  32  new PC; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = LOOKUP; all valid bits = 0; discard = 0.
  - mem_req_o = 0, mem_addr_o = 0.
  - inst_valid_o = 0, inst_o = 0, inst_pc_o = 0.
- Address split: index = pc[INDEX_W+1:2]; tag = pc[31:INDEX_W+2]. Hit = valid[index] && tag_arr[index] == tag.
- rdy low: no register changes. inst_valid_o is also frozen (the queue gates on rdy too).
- inst_valid_o defaults to 0 every rdy cycle unless set below.
- State LOOKUP, priority order:
  1. redirect_i: pc <= {redirect_pc_i[31:2],2'b0}; no output; stay in LOOKUP.
  2. Hit && !iq_full_i: inst_valid_o <= 1, inst_o <= data_arr[index], inst_pc_o <= pc, pc <= pc+4 (wraps modulo 2^32). Hit latency is 1 cycle. Sustained throughput is 1 instruction/cycle.
  3. Hit && iq_full_i: hold; no output.
  4. Miss: mem_req_o <= 1, mem_addr_o <= pc; go to MISS.
- State MISS:
  - mem_req_o and mem_addr_o stay constant.
  - redirect_i: the memory controller has no cancel, so the outstanding read completes. Set discard <= 1 and record pending_pc <= redirect target. A later redirect overwrites pending_pc; the last one wins.
  - mem_done_i: mem_req_o <= 0.
    - Write data_arr/tag_arr at the index of mem_addr_o and set its valid bit. The fill is always performed because it is correct data.
    - If discard (or redirect_i in the same cycle): pc <= pending/redirect target, discard <= 0.
    - Go to LOOKUP. The instruction is not forwarded directly; the next LOOKUP hits, so miss-to-output = done + 2 cycles.
  - redirect_i and mem_done_i in the same cycle: the redirect target wins for pc; the fill still occurs.
- Redirect and hit in the same cycle: the redirect wins and no instruction is emitted.
- There is no self-modifying-code coherence; the cache is cleared only by reset. Reset mid-miss drops the request (mem_req_o = 0); the memory controller is reset concurrently.
- pc wraparound from 32'hFFFF_FFFC goes to 32'h0 with no special handling.

Decomposition:
- Shared definitions package:
  - ADDR/INST width constants, the RESET_PC default.
  - Fetch state encoding (LOOKUP = 0, MISS = 1).
  - ICACHE_LINES/INDEX_W constants.
- One sub-module, icache_array:
  - Holds the valid/tag/data storage.
  - Combinational read (hit, data) on index/tag.
  - Synchronous write port (fill_en, fill_addr, fill_data).
  - Clears valid bits on rst.
- The fetcher FSM lives in the top module.

Test Plan:
- Cold start, RESET_PC = 0, memory word 0 = 32'h00000013:
  - mem_req_o rises in cycle 1 with mem_addr_o = 0.
  - After mem_done_i, inst_valid_o pulses 2 cycles later with inst_o = 32'h00000013, inst_pc_o = 0.
- Hit streaming with lines 0x0–0xC pre-filled and iq_full_i = 0: four consecutive inst_valid_o pulses with inst_pc_o = 0, 4, 8, C.
- Back-pressure: iq_full_i = 1 for 3 cycles during a hit → no pulses and pc held; the pulse resumes the cycle after iq_full_i falls.
- Redirect during miss:
  - Miss at 0x100; redirect_i with redirect_pc_i = 0x40 two cycles later.
  - After mem_done_i, line 0x100 is valid and the next fetch address is 0x40.
  - No instruction is emitted with inst_pc_o = 0x100.
- Redirect and mem_done_i in the same cycle: pc = redirect target; the filled line hits on a later fetch of the same address with no mem_req_o.
- Aliasing with 64 lines: fetch 0x000 then 0x100 → the second access misses and evicts the first; refetching 0x000 misses again (mem_req_o asserted).

Source files
------------

// File: rtl/icache_fetcher_pkg.sv
// rtl/icache_fetcher_pkg.sv - shared widths, cache geometry and fetch state encoding
package icache_fetcher_pkg;
    localparam int          ADDR_W           = 32;
    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEF     = 32'h0;
    localparam int          ICACHE_LINES_DEF = 64;
    localparam int          INDEX_W_DEF      = 6;

    typedef enum logic {
        LOOKUP = 1'b0,
        MISS   = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped one-word-per-line valid/tag/data storage
module icache_array
    import icache_fetcher_pkg::*;
#(
    parameter int LINES = ICACHE_LINES_DEF,
    parameter int IDX_W = INDEX_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IDX_W-1:0]          i_rd_index,
    input  logic [ADDR_W-IDX_W-3:0]   i_rd_tag,
    output logic                      o_hit,
    output logic [INST_W-1:0]         o_data,
    input  logic                      i_fill_en,
    input  logic [IDX_W-1:0]          i_fill_index,
    input  logic [ADDR_W-IDX_W-3:0]   i_fill_tag,
    input  logic [INST_W-1:0]         i_fill_data
);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [INST_W-1:0] r_data [LINES];

    assign o_hit  = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
    assign o_data = r_data[i_rd_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[i_fill_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_fill_index]  <= i_fill_tag;
            r_data[i_fill_index] <= i_fill_data;
        end
    end
endmodule

// File: rtl/icache_fetcher.sv
// rtl/icache_fetcher.sv - PC, hit streaming and miss refill FSM in front of the memory controller
module icache_fetcher
    import icache_fetcher_pkg::*;
#(
    parameter int          ICACHE_LINES = ICACHE_LINES_DEF,
    parameter int          INDEX_W      = INDEX_W_DEF,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_done_i,
    input  logic [INST_W-1:0] mem_data_i,
    input  logic              iq_full_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);
    fetch_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_inst_valid, w_inst_valid_nxt;
    logic [INST_W-1:0] r_inst, w_inst_nxt;
    logic [ADDR_W-1:0] r_inst_pc, w_inst_pc_nxt;
    logic              r_discard, w_discard_nxt;
    logic [ADDR_W-1:0] r_pending_pc, w_pending_pc_nxt;
    logic              w_fill;
    logic              w_hit;
    logic [INST_W-1:0] w_data;
    logic [ADDR_W-1:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

    icache_array #(.LINES(ICACHE_LINES), .IDX_W(INDEX_W)) u_array (
        .clk          (clk),
        .rst          (rst),
        .i_rd_index   (r_pc[INDEX_W+1:2]),
        .i_rd_tag     (r_pc[ADDR_W-1:INDEX_W+2]),
        .o_hit        (w_hit),
        .o_data       (w_data),
        .i_fill_en    (w_fill && rdy && !rst),
        .i_fill_index (r_mem_addr[INDEX_W+1:2]),
        .i_fill_tag   (r_mem_addr[ADDR_W-1:INDEX_W+2]),
        .i_fill_data  (mem_data_i)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_mem_req_nxt    = r_mem_req;
        w_mem_addr_nxt   = r_mem_addr;
        w_inst_valid_nxt = 1'b0;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_discard_nxt    = r_discard;
        w_pending_pc_nxt = r_pending_pc;
        w_fill           = 1'b0;
        case (r_state)
            LOOKUP: begin
                if (redirect_i) begin
                    w_pc_nxt = w_redirect_pc;
                end else if (w_hit) begin
                    if (!iq_full_i) begin
                        w_inst_valid_nxt = 1'b1;
                        w_inst_nxt       = w_data;
                        w_inst_pc_nxt    = r_pc;
                        w_pc_nxt         = r_pc + 32'd4;
                    end
                end else begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = r_pc;
                    w_state_nxt    = MISS;
                end
            end
            MISS: begin
                // The read cannot be cancelled; a redirect is parked until it returns.
                if (redirect_i) begin
                    w_discard_nxt    = 1'b1;
                    w_pending_pc_nxt = w_redirect_pc;
                end
                if (mem_done_i) begin
                    w_mem_req_nxt = 1'b0;
                    w_fill        = 1'b1;
                    w_state_nxt   = LOOKUP;
                    w_discard_nxt = 1'b0;
                    if (redirect_i) begin
                        w_pc_nxt = w_redirect_pc;
                    end else if (r_discard) begin
                        w_pc_nxt = r_pending_pc;
                    end
                end
            end
            default: w_state_nxt = LOOKUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= LOOKUP;
            r_pc         <= RESET_PC;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_discard    <= 1'b0;
            r_pending_pc <= '0;
        end else if (rdy) begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_discard    <= w_discard_nxt;
            r_pending_pc <= w_pending_pc_nxt;
        end
    end

    assign mem_req_o    = r_mem_req;
    assign mem_addr_o   = r_mem_addr;
    assign inst_valid_o = r_inst_valid;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
endmodule
